// File: rtl/fetch_decode_seq.sv
// fetch_decode_seq: instruction register and T-state sequencer for the CTI-8 core.
// Fetches one instruction byte per instruction (T0 address, T1 read with
// unbounded wait states) and executes it in T2 (and T3 for ADDI).
// Drives every bus-control strobe combinationally from state, IR and memReady.
// The constant-stage nibble port is named constNib because "const" is a
// reserved word in SystemVerilog.
module fetch_decode_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dataBus,
  input  logic       memReady,
  output logic [3:0] constNib,
  output logic       constOe,
  output logic       pcOe,
  output logic       marLoad,
  output logic       ramOe,
  output logic       irLoad,
  output logic       pcInc,
  output logic       aLoad,
  output logic       bLoad,
  output logic       aluOe,
  output logic       halted,
  output logic [2:0] tstate
);

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_LDI  = 4'h1;
  localparam logic [3:0] OPC_ADDI = 4'h2;
  localparam logic [3:0] OPC_HLT  = 4'hF;

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    HALT = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_ir;
  logic       r_halted;

  // State, instruction register and halt flag; IR only loads on the T1 ready edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= T0;
      r_ir     <= 8'h00;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == HALT);
      if (irLoad) begin
        r_ir <= dataBus;
      end
    end
  end

  // Next-state decode and strobe generation; reset suppresses every strobe.
  always_comb begin
    w_next  = r_state;
    pcOe    = 1'b0;
    marLoad = 1'b0;
    ramOe   = 1'b0;
    irLoad  = 1'b0;
    pcInc   = 1'b0;
    constOe = 1'b0;
    aLoad   = 1'b0;
    bLoad   = 1'b0;
    aluOe   = 1'b0;
    case (r_state)
      T0: begin
        pcOe    = 1'b1;
        marLoad = 1'b1;
        w_next  = T1;
      end
      T1: begin
        ramOe = 1'b1;
        if (memReady) begin
          irLoad = 1'b1;
          pcInc  = 1'b1;
          w_next = T2;
        end
      end
      T2: begin
        case (r_ir[7:4])
          OPC_LDI: begin
            constOe = 1'b1;
            aLoad   = 1'b1;
            w_next  = T0;
          end
          OPC_ADDI: begin
            constOe = 1'b1;
            bLoad   = 1'b1;
            w_next  = T3;
          end
          OPC_HLT: w_next = HALT;
          OPC_NOP: w_next = T0;
          default: w_next = T0;
        endcase
      end
      T3: begin
        aluOe  = 1'b1;
        aLoad  = 1'b1;
        w_next = T0;
      end
      HALT:    w_next = HALT;
      default: w_next = T0;
    endcase
    if (rst) begin
      pcOe    = 1'b0;
      marLoad = 1'b0;
      ramOe   = 1'b0;
      irLoad  = 1'b0;
      pcInc   = 1'b0;
      constOe = 1'b0;
      aLoad   = 1'b0;
      bLoad   = 1'b0;
      aluOe   = 1'b0;
    end
  end

  assign constNib = r_ir[3:0];
  assign halted   = r_halted;
  assign tstate   = r_state;

endmodule

// File: tb/tb_fetch_decode_seq.sv
// Directed bench for fetch_decode_seq: reset, LDI, ADDI with wait states,
// undefined opcode, HLT, and reset during T1 wait / T3.
module tb_fetch_decode_seq;

  logic       clk;
  logic       rst;
  logic [7:0] dataBus;
  logic       memReady;
  logic [3:0] constNib;
  logic       constOe, pcOe, marLoad, ramOe, irLoad, pcInc, aLoad, bLoad, aluOe;
  logic       halted;
  logic [2:0] tstate;

  int checks = 0;
  int errors = 0;

  // strobe order: pcOe marLoad ramOe irLoad pcInc constOe aLoad bLoad aluOe
  localparam logic [8:0] S_NONE = 9'b000000000;
  localparam logic [8:0] S_T0   = 9'b110000000;
  localparam logic [8:0] S_T1W  = 9'b001000000;
  localparam logic [8:0] S_T1R  = 9'b001110000;
  localparam logic [8:0] S_LDI  = 9'b000001100;
  localparam logic [8:0] S_ADDI = 9'b000001010;
  localparam logic [8:0] S_T3   = 9'b000000101;

  logic [8:0] strb;
  assign strb = {pcOe, marLoad, ramOe, irLoad, pcInc, constOe, aLoad, bLoad, aluOe};

  fetch_decode_seq dut (
    .clk(clk), .rst(rst), .dataBus(dataBus), .memReady(memReady),
    .constNib(constNib), .constOe(constOe), .pcOe(pcOe), .marLoad(marLoad),
    .ramOe(ramOe), .irLoad(irLoad), .pcInc(pcInc), .aLoad(aLoad), .bLoad(bLoad),
    .aluOe(aluOe), .halted(halted), .tstate(tstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check this cycle's state/strobes, advance.
  task automatic step(input string tag, input logic mr, input logic [7:0] db,
                      input logic [2:0] exp_ts, input logic [8:0] exp_strb);
    memReady = mr;
    dataBus  = db;
    #1;
    chk({tag, ".tstate"}, {13'd0, tstate}, {13'd0, exp_ts});
    chk({tag, ".strobes"}, {7'd0, strb}, {7'd0, exp_strb});
    chk({tag, ".halted"}, {15'd0, halted}, {15'd0, (exp_ts == 3'd7)});
    @(posedge clk);
    #1;
  endtask

  // Reset cycle: strobes must be silent even with memReady high, then state/IR clear.
  task automatic reset_cycle(input string tag);
    rst      = 1'b1;
    memReady = 1'b1;
    dataBus  = 8'hA5;
    #1;
    chk({tag, ".rst_strobes"}, {7'd0, strb}, 16'd0);
    @(posedge clk);
    #1;
    chk({tag, ".post_tstate"}, {13'd0, tstate}, 16'd0);
    chk({tag, ".post_const"}, {12'd0, constNib}, 16'd0);
    chk({tag, ".post_halted"}, {15'd0, halted}, 16'd0);
    rst = 1'b0;
  endtask

  // Bus exclusivity on every cycle.
  always @(negedge clk) begin
    checks++;
    assert ($countones({pcOe, ramOe, constOe, aluOe}) <= 1) else begin
      errors++;
      $error("FAIL bus_excl: observed %b expected at most one set", {pcOe, ramOe, constOe, aluOe});
    end
  end

  initial begin
    rst      = 1'b1;
    memReady = 1'b0;
    dataBus  = 8'hxx;

    // Test 1: reset held two cycles
    @(posedge clk);
    #1;
    chk("t1.rst_strobes0", {7'd0, strb}, 16'd0);
    @(posedge clk);
    #1;
    chk("t1.rst_strobes1", {7'd0, strb}, 16'd0);
    chk("t1.tstate", {13'd0, tstate}, 16'd0);
    chk("t1.const", {12'd0, constNib}, 16'd0);
    chk("t1.halted", {15'd0, halted}, 16'd0);
    rst = 1'b0;

    // Test 2: LDI 8'h1B
    step("t2.T0", 1'b1, 8'hxx, 3'd0, S_T0);
    step("t2.T1", 1'b1, 8'h1B, 3'd1, S_T1R);
    chk("t2.const", {12'd0, constNib}, 16'h000B);
    step("t2.T2", 1'b1, 8'hxx, 3'd2, S_LDI);

    // Test 3: ADDI 8'h27 with three wait states
    step("t3.T0", 1'b0, 8'hxx, 3'd0, S_T0);
    step("t3.T1w0", 1'b0, 8'hxx, 3'd1, S_T1W);
    step("t3.T1w1", 1'b0, 8'hxx, 3'd1, S_T1W);
    chk("t3.const_hold", {12'd0, constNib}, 16'h000B);
    step("t3.T1w2", 1'b0, 8'hxx, 3'd1, S_T1W);
    step("t3.T1r", 1'b1, 8'h27, 3'd1, S_T1R);
    chk("t3.const", {12'd0, constNib}, 16'h0007);
    step("t3.T2", 1'b1, 8'hxx, 3'd2, S_ADDI);
    step("t3.T3", 1'b1, 8'hxx, 3'd3, S_T3);

    // Test 5: undefined opcode 8'h5C
    step("t5.T0", 1'b1, 8'hxx, 3'd0, S_T0);
    step("t5.T1", 1'b1, 8'h5C, 3'd1, S_T1R);
    chk("t5.const", {12'd0, constNib}, 16'h000C);
    step("t5.T2", 1'b1, 8'hxx, 3'd2, S_NONE);

    // Test 4: HLT 8'hF0, stays halted with memReady toggling
    step("t4.T0", 1'b1, 8'hxx, 3'd0, S_T0);
    step("t4.T1", 1'b1, 8'hF0, 3'd1, S_T1R);
    step("t4.T2", 1'b1, 8'hxx, 3'd2, S_NONE);
    for (int i = 0; i < 10; i++) begin
      step("t4.HALT", i[0], 8'hxx, 3'd7, S_NONE);
    end
    chk("t4.const", {12'd0, constNib}, 16'd0);
    reset_cycle("t4.reset");

    // Test 6a: reset during T1 wait after loading a nonzero IR
    step("t6.T0a", 1'b1, 8'hxx, 3'd0, S_T0);
    step("t6.T1a", 1'b1, 8'h1B, 3'd1, S_T1R);
    step("t6.T2a", 1'b1, 8'hxx, 3'd2, S_LDI);
    step("t6.T0b", 1'b0, 8'hxx, 3'd0, S_T0);
    step("t6.T1w", 1'b0, 8'hxx, 3'd1, S_T1W);
    chk("t6.const_pre", {12'd0, constNib}, 16'h000B);
    reset_cycle("t6.rst_t1");

    // Test 6b: reset during T3 of ADDI 8'h2A
    step("t6.T0c", 1'b1, 8'hxx, 3'd0, S_T0);
    step("t6.T1c", 1'b1, 8'h2A, 3'd1, S_T1R);
    step("t6.T2c", 1'b1, 8'hxx, 3'd2, S_ADDI);
    chk("t6.tstate_T3", {13'd0, tstate}, 16'd3);
    reset_cycle("t6.rst_t3");
    step("t6.T0d", 1'b1, 8'hxx, 3'd0, S_T0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
